fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch control stage wrapped around the program counter register: consumes the current `pc`, issues word reads to instruction memory over a request/grant/response handshake, buffers returned instructions in a 2-entry FIFO toward decode, and computes `next_pc` for the PC register. It handles both sequential advance and redirects (branch/JALR), including flushing the FIFO and discarding in-flight responses.

## Interface
- `PC_W`, 10, PC / instruction-memory word-address width
- `INSTR_W`, 16, instruction width
- `FIFO_DEPTH`, 2, instruction buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `pc`  in  PC_W  current PC from the PC register
- `next_pc`  out  PC_W  next PC to the PC register (combinational)
- `redirect_valid`  in  1  branch/JALR taken this cycle
- `redirect_pc`  in  PC_W  redirect target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_W  request address (= `pc`)
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid
- `imem_rdata`  in  INSTR_W  response instruction
- `instr_valid`  out  1  FIFO head valid
- `instr`  out  INSTR_W  FIFO head instruction
- `instr_pc`  out  PC_W  address of FIFO head instruction
- `instr_ready`  in  1  decode accepts head

## Operation
- FSM states: REQ, WAIT, DRAIN. Reset state REQ.
- REQ: `imem_req = (count < FIFO_DEPTH) && !redirect_valid`. Transition to WAIT on `imem_req && imem_gnt`. `pc` is latched into `pend_pc` on grant.
- WAIT: `imem_req = 0`. On `imem_rvalid`, push {`imem_rdata`, `pend_pc`} and go to REQ.
- DRAIN: `imem_req = 0`. On `imem_rvalid`, drop the data and go to REQ.
- At most one outstanding request. A request is issued only when the FIFO has a free slot, so a response always has room.
- `next_pc` priority:
  - `redirect_valid` → `redirect_pc`
  - else `imem_req && imem_gnt` → `pc + 1`, modulo 2^PC_W (1023 wraps to 0)
  - else `pc`
- Redirect behaviour:
  - FIFO is flushed on the same edge; `count` becomes 0.
  - In WAIT without `imem_rvalid` → DRAIN.
  - In WAIT with `imem_rvalid` the same cycle → data dropped, go to REQ.
  - In DRAIN → stay in DRAIN.
  - In REQ → no request that cycle; stay in REQ.
- Simultaneous redirect and `instr_valid && instr_ready`: the flush wins and the head entry is dropped. The redirect source is responsible for killing the decode-side copy.
- Simultaneous push and pop: both happen; `count` is unchanged.
- `instr_valid = (count != 0)`. `instr` and `instr_pc` come straight from the FIFO head registers.

## Timing
- During reset and on its release:
  - state = REQ, `count` = 0, `pend_pc` = 0, FIFO storage = 0
  - `instr_valid`, `instr`, `instr_pc` = 0
  - `imem_req` = 0 while reset is asserted, then follows the REQ rule
- Grant cycle N: the PC register loads `pc + 1` at edge N.
- Response: earliest at cycle N+1. Memory latency is unbounded; the block waits in WAIT indefinitely.
- Entry visible: `instr_valid` rises in the cycle after the `imem_rvalid` cycle (registered FIFO).
- Peak throughput: one instruction per 2 cycles with a 1-cycle-latency memory.
- First request after reset: `imem_req = 1` with `imem_addr = 0` in the first cycle after deassertion.
- Reset mid-fetch: the outstanding request is abandoned. Memory must also be reset; a stale `imem_rvalid` arriving in REQ is ignored.
- Full FIFO: `imem_req` stays low until a pop frees a slot. The request may assert in the cycle after the pop.

## Structure
- Package `fetch_pkg`:
  - `PC_W`, `INSTR_W`, `FIFO_DEPTH` constants
  - `fetch_state_t` enum {REQ, WAIT, DRAIN}
  - `fetch_entry_t` struct {instr, pc}
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, head outputs, and asynchronous reset. Flush has priority over push and pop.
- Top level holds the FSM, `pend_pc`, `next_pc` mux and incrementer.

## Test plan
- Reset then free-run: memory with 1-cycle latency, `instr_ready = 1` → instructions for PCs 0, 1, 2, 3 appear in order, one per 2 cycles; `next_pc` steps 0→1→2→3.
- Backpressure: `instr_ready = 0`, memory always grants → exactly 2 entries (PC 0, 1), then `imem_req` stays 0; raising `instr_ready` for one cycle → one new request, `imem_addr = 2`.
- Redirect in WAIT: grant at PC 5, redirect to 0x200 before `imem_rvalid` → `next_pc = 0x200`, FIFO empty, PC 5 data dropped, next request `imem_addr = 0x200`.
- Redirect coincident with `imem_rvalid` and a pop → FIFO empties, state REQ, no DRAIN cycle, next `imem_addr` = redirect target.
- Wrap: PC 1023 granted → `next_pc = 0`; entry tagged `instr_pc = 1023`.
- Asynchronous reset asserted mid-WAIT → all outputs 0 immediately; after release, first `imem_addr = 0`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

   localparam int PC_W       = 10;
   localparam int INSTR_W    = 16;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/grant/response bus between fetch and imem.
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata
   );

endinterface

// File: rtl/fetch_sequencer_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush beats push and pop.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     mem_q [FIFO_DEPTH];
   fetch_entry_t     mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // NOTE: every signal gets a default before the branches so no latch is inferred.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && (count_q < CNT_W'(FIFO_DEPTH));
      do_pop   = pop && (count_q != '0);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: storage is reset too, so the head outputs read 0 straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: one outstanding imem read, 2-entry buffer toward decode, next-PC mux.
module fetch_sequencer
   import fetch_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_W-1:0]     pc,
   output logic [PC_W-1:0]     next_pc,
   input  logic                redirect_valid,
   input  logic [PC_W-1:0]     redirect_pc,
   fetch_sequencer_if.master   imem,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [PC_W-1:0]     instr_pc,
   input  logic                instr_ready
);

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     push_data;
   logic             grant;
   logic             push;
   logic             pop;

   assign imem.imem_req  = !reset && (state_q == REQ) &&
                           (count < CNT_W'(FIFO_DEPTH)) && !redirect_valid;
   assign imem.imem_addr = pc;
   assign grant          = imem.imem_req && imem.imem_gnt;

   // A response landing alongside a redirect belongs to the old path and is dropped.
   assign push            = (state_q == WAIT) && imem.imem_rvalid && !redirect_valid;
   assign pop             = instr_valid && instr_ready;
   assign push_data.instr = imem.imem_rdata;
   assign push_data.pc    = pend_pc_q;

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;

      case (state_q)
         REQ: begin
            if (grant) begin
               state_d   = WAIT;
               pend_pc_d = pc;
            end
         end
         WAIT: begin
            if (imem.imem_rvalid) begin
               state_d = REQ;
            end else if (redirect_valid) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (imem.imem_rvalid) begin
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= REQ;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   always_comb begin
      if (redirect_valid) begin
         next_pc = redirect_pc;
      end else if (grant) begin
         next_pc = pc + PC_W'(1);
      end else begin
         next_pc = pc;
      end
   end

   fetch_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head)
   );

   assign instr_valid = (count != '0);
   assign instr       = head.instr;
   assign instr_pc    = head.pc;

endmodule
